// File: rtl/i2s_pkg.sv
// Shared I2S/TDM constants: configuration code tables, reset defaults and the
// timer state encoding used by the transmitter, receiver and frame timer.
package i2s_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] WW_CODE_16 = 2'd0;
  localparam logic [1:0] WW_CODE_24 = 2'd1;
  localparam logic [1:0] WW_CODE_32 = 2'd2;

  localparam logic [2:0] TDM_CODE_2  = 3'd0;
  localparam logic [2:0] TDM_CODE_4  = 3'd1;
  localparam logic [2:0] TDM_CODE_8  = 3'd2;
  localparam logic [2:0] TDM_CODE_16 = 3'd3;

  localparam logic [5:0] RST_WORD_WIDTH = 6'd16;
  localparam logic [4:0] RST_SLOT_NUM   = 5'd2;
  localparam logic [9:0] RST_FRAME_BITS = 10'd32;

  // Reserved codes decode to zero so callers can detect them.
  function automatic logic [5:0] word_width_of(input logic [1:0] code);
    case (code)
      WW_CODE_16: word_width_of = 6'd16;
      WW_CODE_24: word_width_of = 6'd24;
      WW_CODE_32: word_width_of = 6'd32;
      default:    word_width_of = 6'd0;
    endcase
  endfunction

  function automatic logic [4:0] slot_num_of(input logic [2:0] code);
    case (code)
      TDM_CODE_2:  slot_num_of = 5'd2;
      TDM_CODE_4:  slot_num_of = 5'd4;
      TDM_CODE_8:  slot_num_of = 5'd8;
      TDM_CODE_16: slot_num_of = 5'd16;
      default:     slot_num_of = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/tdm_cfg_decode.sv
// Registered decode of width/slot codes into word width, slot count and frame
// length; one-cycle latency, captures only on i_load and holds otherwise.
module tdm_cfg_decode
  import i2s_pkg::*;
#(
  parameter int MAX_SLOTS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [1:0] i_word_code,
  input  logic [2:0] i_tdm_code,
  output logic [5:0] o_word_width,
  output logic [4:0] o_slot_num,
  output logic [9:0] o_frame_bits,
  output logic       o_code_ok
);

  localparam logic [5:0] MAX_SN = 6'(MAX_SLOTS);

  logic [5:0] w_ww;
  logic [4:0] w_sn;
  logic [5:0] r_ww;
  logic [4:0] r_sn;
  logic [9:0] r_fb;
  logic       r_ok;

  assign w_ww = word_width_of(i_word_code);
  assign w_sn = slot_num_of(i_tdm_code);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ww <= RST_WORD_WIDTH;
      r_sn <= RST_SLOT_NUM;
      r_fb <= RST_FRAME_BITS;
      r_ok <= 1'b1;
    end else if (i_load) begin
      r_ww <= w_ww;
      r_sn <= w_sn;
      r_fb <= 10'(w_ww) * 10'(w_sn);
      r_ok <= (w_ww != 6'd0) && (w_sn != 5'd0) && ({1'b0, w_sn} <= MAX_SN);
    end
  end

  assign o_word_width = r_ww;
  assign o_slot_num   = r_sn;
  assign o_frame_bits = r_fb;
  assign o_code_ok    = r_ok;

endmodule

// File: rtl/tdm_frame_timer.sv
// TDM/I2S frame timer: slot/bit counters, strobes and fsync advanced by bit_tick;
// configuration changes are held pending and only applied on a frame boundary.
module tdm_frame_timer
  import i2s_pkg::*;
#(
  parameter int MAX_SLOTS   = 16,
  parameter bit FSYNC_PULSE = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         bit_tick,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [1:0]                   cfg_word_width,
  input  logic [2:0]                   cfg_tdm_num,
  output logic                         cfg_err,
  output logic [5:0]                   word_width_real,
  output logic [4:0]                   slot_num_real,
  output logic [9:0]                   frame_bits,
  output logic [$clog2(MAX_SLOTS)-1:0] slot_idx,
  output logic [4:0]                   bit_idx,
  output logic                         frame_start,
  output logic                         slot_start,
  output logic                         fsync
);

  localparam int SW = $clog2(MAX_SLOTS);

  state_t        r_state;
  logic          r_busy, r_dec_vld, r_first, r_err;
  logic [5:0]    r_ww;
  logic [4:0]    r_sn;
  logic [9:0]    r_fb;
  logic [SW-1:0] r_slot;
  logic [4:0]    r_bit;
  logic          r_frame_start, r_slot_start, r_fsync;

  logic          w_accept, w_have, w_reject, w_apply;
  logic          w_tick_run, w_last_bit, w_last_slot, w_wrap, w_nfsync;
  logic [5:0]    w_dec_ww;
  logic [4:0]    w_dec_sn, w_n_eff, w_nbit;
  logic [9:0]    w_dec_fb;
  logic          w_dec_ok;
  logic [SW-1:0] w_nslot;

  tdm_cfg_decode #(.MAX_SLOTS(MAX_SLOTS)) u_decode (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (w_accept),
    .i_word_code  (cfg_word_width),
    .i_tdm_code   (cfg_tdm_num),
    .o_word_width (w_dec_ww),
    .o_slot_num   (w_dec_sn),
    .o_frame_bits (w_dec_fb),
    .o_code_ok    (w_dec_ok)
  );

  assign w_accept = cfg_valid & ~r_busy;
  assign w_reject = r_dec_vld & ~w_dec_ok;
  // The decoder holds the pending values while busy, so no separate copy is kept.
  assign w_have   = r_busy & ~w_reject;

  assign w_tick_run  = (r_state == ST_RUN) & enable & bit_tick;
  assign w_last_bit  = (r_bit == 5'(r_ww - 6'd1));
  assign w_last_slot = (5'(r_slot) == (r_sn - 5'd1));
  assign w_wrap      = w_tick_run & ~r_first & w_last_bit & w_last_slot;
  assign w_apply     = w_have & ((r_state == ST_IDLE) | w_wrap);
  assign w_n_eff     = w_apply ? w_dec_sn : r_sn;

  // The first tick after enabling claims slot 0, bit 0 instead of advancing.
  always_comb begin
    w_nbit  = 5'd0;
    w_nslot = '0;
    if (!r_first) begin
      if (!w_last_bit) begin
        w_nbit  = r_bit + 5'd1;
        w_nslot = r_slot;
      end else if (!w_last_slot) begin
        w_nslot = r_slot + SW'(1);
      end
    end
  end

  assign w_nfsync = FSYNC_PULSE ? ((w_nbit == 5'd0) && (w_nslot == '0))
                                : (5'(w_nslot) < (w_n_eff >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_dec_vld     <= 1'b0;
      r_first       <= 1'b0;
      r_err         <= 1'b0;
      r_ww          <= RST_WORD_WIDTH;
      r_sn          <= RST_SLOT_NUM;
      r_fb          <= RST_FRAME_BITS;
      r_slot        <= '0;
      r_bit         <= 5'd0;
      r_frame_start <= 1'b0;
      r_slot_start  <= 1'b0;
      r_fsync       <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_slot_start  <= 1'b0;
      r_dec_vld     <= w_accept;
      if (w_accept) r_busy <= 1'b1;
      else if (w_apply || w_reject) r_busy <= 1'b0;
      if (w_reject) r_err <= 1'b1;
      if (w_apply) begin
        r_ww <= w_dec_ww;
        r_sn <= w_dec_sn;
        r_fb <= w_dec_fb;
      end
      case (r_state)
        ST_IDLE: begin
          r_slot  <= '0;
          r_bit   <= 5'd0;
          r_fsync <= 1'b0;
          if (enable) begin
            r_state <= ST_RUN;
            r_first <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_bit   <= 5'd0;
            r_fsync <= 1'b0;
          end else if (bit_tick) begin
            r_first       <= 1'b0;
            r_bit         <= w_nbit;
            r_slot        <= w_nslot;
            r_slot_start  <= (w_nbit == 5'd0);
            r_frame_start <= (w_nbit == 5'd0) && (w_nslot == '0);
            r_fsync       <= w_nfsync;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready       = ~r_busy;
  assign cfg_err         = r_err;
  assign word_width_real = r_ww;
  assign slot_num_real   = r_sn;
  assign frame_bits      = r_fb;
  assign slot_idx        = r_slot;
  assign bit_idx         = r_bit;
  assign frame_start     = r_frame_start;
  assign slot_start      = r_slot_start;
  assign fsync           = r_fsync;

endmodule

// File: tb/tb_tdm_frame_timer.sv
// Bench for tdm_frame_timer: instance A (16 slots, 50% fsync) and instance B
// (8 slots, pulse fsync) share stimulus; per-tick expectations come from a frame-position model.
module tb_tdm_frame_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, bit_tick, cfg_valid;
  logic [1:0] cfg_word_width;
  logic [2:0] cfg_tdm_num;

  logic       a_ready, a_err, a_fs, a_ss, a_fy;
  logic [5:0] a_ww;
  logic [4:0] a_sn, a_bit;
  logic [9:0] a_fb;
  logic [3:0] a_slot;

  logic       b_ready, b_err, b_fs, b_ss, b_fy;
  logic [5:0] b_ww;
  logic [4:0] b_sn, b_bit;
  logic [9:0] b_fb;
  logic [2:0] b_slot;

  tdm_frame_timer #(.MAX_SLOTS(16), .FSYNC_PULSE(1'b0)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .bit_tick(bit_tick),
    .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .cfg_word_width(cfg_word_width), .cfg_tdm_num(cfg_tdm_num),
    .cfg_err(a_err), .word_width_real(a_ww), .slot_num_real(a_sn),
    .frame_bits(a_fb), .slot_idx(a_slot), .bit_idx(a_bit),
    .frame_start(a_fs), .slot_start(a_ss), .fsync(a_fy)
  );

  tdm_frame_timer #(.MAX_SLOTS(8), .FSYNC_PULSE(1'b1)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .bit_tick(bit_tick),
    .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .cfg_word_width(cfg_word_width), .cfg_tdm_num(cfg_tdm_num),
    .cfg_err(b_err), .word_width_real(b_ww), .slot_num_real(b_sn),
    .frame_bits(b_fb), .slot_idx(b_slot), .bit_idx(b_bit),
    .frame_start(b_fs), .slot_start(b_ss), .fsync(b_fy)
  );

  typedef struct {
    int inst;
    int slot;
    int bitn;
    bit fs;
    bit ss;
    bit fy;
  } exp_t;

  typedef struct {
    logic [1:0] wc;
    logic [2:0] tc;
    int a_ww, a_sn, a_fb;
    bit a_err;
    int b_sn;
    bit b_err;
  } cfg_vec_t;

  exp_t     sb_q[$];
  cfg_vec_t vecs[6];
  int n_vec = 0, n_bad = 0;
  int b_fy_cnt = 0, b_ss_cnt = 0;

  // Model: frame position per instance, active W/N and one pending config.
  int m_w[2], m_n[2], m_pos[2], m_pw[2], m_pn[2];
  bit m_pend[2];
  bit m_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_w[i] = 16; m_n[i] = 2; m_pos[i] = -1; m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_offer(input logic [1:0] wc, input logic [2:0] tc);
    int w, n;
    w = (wc == 2'd0) ? 16 : (wc == 2'd1) ? 24 : (wc == 2'd2) ? 32 : 0;
    n = (tc < 3'd4) ? (2 << tc) : 0;
    for (int i = 0; i < 2; i++) begin
      if (w != 0 && n != 0 && n <= ((i == 0) ? 16 : 8)) begin
        if (m_run) begin
          m_pend[i] = 1'b1; m_pw[i] = w; m_pn[i] = n;
        end else begin
          m_w[i] = w; m_n[i] = n;
        end
      end
    end
  endtask

  task automatic model_tick();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = (m_pos[i] < 0) ? 0 : m_pos[i] + 1;
      if (m_pos[i] == m_w[i] * m_n[i]) begin
        m_pos[i] = 0;
        if (m_pend[i]) begin
          m_w[i] = m_pw[i]; m_n[i] = m_pn[i]; m_pend[i] = 1'b0;
        end
      end
      e.inst = i;
      e.slot = m_pos[i] / m_w[i];
      e.bitn = m_pos[i] % m_w[i];
      e.fs   = (m_pos[i] == 0);
      e.ss   = (e.bitn == 0);
      e.fy   = (i == 1) ? (m_pos[i] == 0) : (e.slot < m_n[i] / 2);
      sb_q.push_back(e);
    end
  endtask

  task automatic offer(input logic [1:0] wc, input logic [2:0] tc);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_word_width = wc; cfg_tdm_num = tc;
    model_offer(wc, tc);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bit_tick = 1'b1;
    if (m_run) model_tick();
    @(posedge clk); #1;
    bit_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " A ww"}, a_ww, 16);   check({tag, " B ww"}, b_ww, 16);
    check({tag, " A sn"}, a_sn, 2);    check({tag, " B sn"}, b_sn, 2);
    check({tag, " A fb"}, a_fb, 32);   check({tag, " B fb"}, b_fb, 32);
    check({tag, " A rdy"}, a_ready, 1); check({tag, " B rdy"}, b_ready, 1);
    check({tag, " A err"}, a_err, 0);  check({tag, " B err"}, b_err, 0);
    check({tag, " A cnt"}, {a_slot, a_bit}, 0);
    check({tag, " B cnt"}, {b_slot, b_bit}, 0);
    check({tag, " A strobes"}, {a_fs, a_ss, a_fy}, 0);
    check({tag, " B strobes"}, {b_fs, b_ss, b_fy}, 0);
  endtask

  // Pops expectations for the tick sampled on the preceding rising edge.
  task automatic monitor();
    logic t;
    exp_t e;
    logic [31:0] act, exp;
    forever begin
      @(posedge clk);
      t = bit_tick;
      @(negedge clk);
      if (t) begin
        if (sb_q.size() >= 2) begin
          for (int i = 0; i < 2; i++) begin
            e = sb_q.pop_front();
            exp = {8'(e.slot), 8'(e.bitn), 13'd0, e.fs, e.ss, e.fy};
            if (e.inst == 0) act = {8'(a_slot), 8'(a_bit), 13'd0, a_fs, a_ss, a_fy};
            else begin
              act = {8'(b_slot), 8'(b_bit), 13'd0, b_fs, b_ss, b_fy};
              if (b_fy) b_fy_cnt++;
              if (b_ss) b_ss_cnt++;
            end
            check($sformatf("tick inst%0d slot/bit/fs/ss/fy", e.inst), act, exp);
          end
        end else begin
          check("idle tick strobes", {a_fs, a_ss, a_fy, b_fs, b_ss, b_fy}, 0);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fy0, ss0;
    rst = 1'b1; enable = 1'b0; bit_tick = 1'b0; cfg_valid = 1'b0;
    cfg_word_width = 2'd0; cfg_tdm_num = 3'd0;
    m_run = 1'b0;
    model_reset();
    fork monitor(); join_none

    vecs[0] = '{2'd0, 3'd0, 16, 2,  32,  1'b0, 2, 1'b0};
    vecs[1] = '{2'd1, 3'd1, 24, 4,  96,  1'b0, 4, 1'b0};
    vecs[2] = '{2'd2, 3'd2, 32, 8,  256, 1'b0, 8, 1'b0};
    vecs[3] = '{2'd0, 3'd3, 16, 16, 256, 1'b0, 8, 1'b1};
    vecs[4] = '{2'd3, 3'd1, 16, 16, 256, 1'b1, 8, 1'b1};
    vecs[5] = '{2'd2, 3'd3, 32, 16, 512, 1'b1, 8, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Configuration table, applied while idle.
    for (int k = 0; k < 6; k++) begin
      offer(vecs[k].wc, vecs[k].tc);
      check($sformatf("vec%0d A rdy low", k), a_ready, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d A rdy", k), a_ready, 1);
      check($sformatf("vec%0d A ww", k), a_ww, vecs[k].a_ww);
      check($sformatf("vec%0d A sn", k), a_sn, vecs[k].a_sn);
      check($sformatf("vec%0d A fb", k), a_fb, vecs[k].a_fb);
      check($sformatf("vec%0d A err", k), a_err, vecs[k].a_err);
      check($sformatf("vec%0d B sn", k), b_sn, vecs[k].b_sn);
      check($sformatf("vec%0d B err", k), b_err, vecs[k].b_err);
    end

    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset("reset after cfg");
    rst = 1'b0;
    model_reset();

    // Default 16x2 frames.
    enable = 1'b1; m_run = 1'b1;
    run_ticks(40);

    // Mid-frame change to 32x8 waits for the frame end.
    offer(2'd2, 3'd2);
    check("pending A rdy", a_ready, 0);
    check("pending B rdy", b_ready, 0);
    run_ticks(24);
    check("pending A rdy at frame end", a_ready, 0);
    tick();
    check("applied A rdy", a_ready, 1);
    check("applied A ww", a_ww, 32);
    check("applied A sn", a_sn, 8);
    check("applied A fb", a_fb, 256);
    run_ticks(10);

    // Reserved word code while running.
    offer(2'd3, 3'd0);
    check("reject A rdy low", a_ready, 0);
    @(posedge clk); #1;
    check("reject A rdy", a_ready, 1);
    check("reject A err", a_err, 1);
    check("reject B err", b_err, 1);
    check("reject A ww kept", a_ww, 32);
    check("reject A sn kept", a_sn, 8);
    run_ticks(5);

    // Reset with a pending configuration drops it.
    offer(2'd1, 3'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid-frame reset");
    rst = 1'b0;
    model_reset();
    run_ticks(40);

    // Disable mid-frame.
    @(posedge clk); #1 enable = 1'b0; m_run = 1'b0;
    @(posedge clk); #1;
    check("disable A cnt", {a_slot, a_bit}, 0);
    check("disable B cnt", {b_slot, b_bit}, 0);
    check("disable strobes", {a_fs, a_ss, a_fy, b_fs, b_ss, b_fy}, 0);
    run_ticks(2);
    model_reset();

    // 24-bit, 4-slot frames; B gives a one-tick fsync pulse.
    offer(2'd1, 3'd1);
    @(posedge clk); #1;
    check("24x4 B ww", b_ww, 24);
    check("24x4 B sn", b_sn, 4);
    check("24x4 B fb", b_fb, 96);
    fy0 = b_fy_cnt; ss0 = b_ss_cnt;
    enable = 1'b1; m_run = 1'b1;
    run_ticks(200);
    check("24x4 B fsync pulses", b_fy_cnt - fy0, 3);
    check("24x4 B slot starts", b_ss_cnt - ss0, 9);

    repeat (4) @(posedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
